// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared definitions for the sram-like responder.
//   SIZE_*        : encodings of the request size field (3 is treated as word)
//   resp_entry_t  : one outstanding-response slot in the response queue
//   byte_en()     : SRAM byte-lane mask for a size / low address pair
//   is_aligned()  : natural-alignment test for a size / low address pair
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        is_read;
        logic        misalign;
        logic        captured;   // read word already copied out of ram_rdata
        logic [31:0] rdata;
        logic [2:0]  ready_cnt;  // remaining extra-latency cycles
    } resp_entry_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: byte_en = 4'b0001 << lo;
            SIZE_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: byte_en = 4'b1111;
            default:   byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: is_aligned = 1'b1;
            SIZE_HALF: is_aligned = ~lo[0];
            SIZE_WORD: is_aligned = (lo == 2'b00);
            default:   is_aligned = (lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo: DEPTH-deep in-order queue of outstanding responses.
//   clk, rst      : clock, asynchronous active-high reset (discards all entries)
//   push          : append an entry (never asserted while full)
//   push_is_read  : entry is a read
//   push_misalign : entry is a misaligned request
//   pop           : retire the head (only asserted when head_ready)
//   ram_rdata     : SRAM read data, captured by the entry pushed last cycle
//   head_ready    : head present and its latency countdown expired
//   head_misalign : head misalign flag
//   head_rdata    : head read word (0 for writes)
//   full_next     : queue will be full in the next cycle
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned EXTRA_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        push_is_read,
    input  logic        push_misalign,
    input  logic        pop,
    input  logic [31:0] ram_rdata,
    output logic        head_ready,
    output logic        head_misalign,
    output logic [31:0] head_rdata,
    output logic        full_next
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    resp_entry_t      entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    resp_entry_t      head;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign count_next = count + CW'(push) - CW'(pop);
    assign full_next  = (count_next == CW'(DEPTH));

    assign head          = entries[rd_ptr];
    assign head_ready    = valid[rd_ptr] && (head.ready_cnt == 3'd0);
    assign head_misalign = head.misalign;
    // With no extra latency the head retires in the very cycle the SRAM
    // presents its word, so the uncaptured head reads ram_rdata directly.
    assign head_rdata    = !head.is_read ? '0 : (head.captured ? head.rdata : ram_rdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid[i]) begin
                    if (!entries[i].captured) begin
                        entries[i].captured <= 1'b1;
                        entries[i].rdata    <= entries[i].is_read ? ram_rdata : '0;
                    end
                    if (entries[i].ready_cnt != 3'd0) begin
                        entries[i].ready_cnt <= entries[i].ready_cnt - 3'd1;
                    end
                end
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= wrap_inc(rd_ptr);
            end
            if (push) begin
                entries[wr_ptr] <= '{is_read:   push_is_read,
                                     misalign:  push_misalign,
                                     captured:  1'b0,
                                     rdata:     32'd0,
                                     ready_cnt: 3'(EXTRA_LAT)};
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= wrap_inc(wr_ptr);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/sram_like_slave.sv
// sram_like_slave: sram-like channel responder backed by a 1-cycle SRAM.
//   clk, rst        : clock, asynchronous active-high reset
//   req/wr/size     : request valid, write flag, size (0 byte,1 half,2/3 word)
//   addr, wdata     : byte address, lane-aligned write data
//   addr_ok         : request accepted when req & addr_ok (state-only)
//   data_ok, rdata  : one in-order response per request; rdata 0 for writes
//   misalign        : flags the response of a misaligned request
//   ram_*           : single-port synchronous SRAM interface
// Optional: define SRAM_LIKE_SLV_RANDOM_STALL_EN to add LFSR-driven random
// acceptance and retirement stalls.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int unsigned RAM_AW    = 16,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned EXTRA_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              misalign
);

    logic        accept;
    logic        aligned;
    logic [3:0]  lanes;
    logic        full_next;
    logic        head_ready;
    logic        head_misalign;
    logic [31:0] head_rdata;
    logic [31:0] rdata_hold;
    logic        accept_gate;
    logic        retire_gate;
    logic        unused_addr;

    assign accept    = req & addr_ok;
    assign lanes     = byte_en(size, addr[1:0]);
    assign aligned   = is_aligned(size, addr[1:0]);
    assign ram_en    = accept;
    assign ram_wen   = (accept && wr && aligned) ? lanes : '0;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;
    assign unused_addr = ^addr[31:RAM_AW+2];

`ifdef SRAM_LIKE_SLV_RANDOM_STALL_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= lfsr_next;
    end

    // addr_ok is registered, so its mask looks at the value lfsr takes next.
    assign accept_gate = (lfsr_next[1:0] != 2'b00);
    assign retire_gate = (lfsr[3:2] != 2'b00);
`else
    assign accept_gate = 1'b1;
    assign retire_gate = 1'b1;
`endif

    assign data_ok  = head_ready & retire_gate;
    assign misalign = data_ok & head_misalign;
    assign rdata    = data_ok ? head_rdata : rdata_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_ok    <= 1'b0;
            rdata_hold <= '0;
        end else begin
            addr_ok <= !full_next && accept_gate;
            if (data_ok) rdata_hold <= head_rdata;
        end
    end

    sram_like_resp_fifo #(
        .DEPTH     (MAX_OUTST),
        .EXTRA_LAT (EXTRA_LAT)
    ) u_resp_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (accept),
        .push_is_read  (~wr),
        .push_misalign (~aligned),
        .pop           (data_ok),
        .ram_rdata     (ram_rdata),
        .head_ready    (head_ready),
        .head_misalign (head_misalign),
        .head_rdata    (head_rdata),
        .full_next     (full_next)
    );

endmodule

// File: tb/tb_sram_like_slave.sv
module tb_sram_like_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        addr_ok0, data_ok0, ram_en0, misalign0;
    logic [31:0] rdata0, ram_wdata0, ram_rdata0;
    logic [3:0]  ram_wen0;
    logic [15:0] ram_addr0;

    logic        addr_ok1, data_ok1, ram_en1, misalign1;
    logic [31:0] rdata1, ram_wdata1, ram_rdata1;
    logic [3:0]  ram_wen1;
    logic [15:0] ram_addr1;

    logic [31:0] mem0 [65536];
    logic [31:0] mem1 [65536];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          due;
        logic        mis;
        logic [31:0] data;
    } exp_t;

    always #5 clk = ~clk;

    sram_like_slave #(.RAM_AW(16), .MAX_OUTST(2), .EXTRA_LAT(0)) u0 (
        .clk(clk), .rst(rst), .req(req0), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0),
        .ram_en(ram_en0), .ram_wen(ram_wen0), .ram_addr(ram_addr0),
        .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0), .misalign(misalign0));

    sram_like_slave #(.RAM_AW(16), .MAX_OUTST(2), .EXTRA_LAT(3)) u1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1),
        .ram_en(ram_en1), .ram_wen(ram_wen1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .misalign(misalign1));

    // Synchronous single-port SRAMs, one read cycle.
    always @(posedge clk) begin
        if (ram_en0) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen0[b]) mem0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
            ram_rdata0 <= mem0[ram_addr0];
        end
        if (ram_en1) begin
            for (int b = 0; b < 4; b++)
                if (ram_wen1[b]) mem1[ram_addr1][8*b +: 8] <= ram_wdata1[8*b +: 8];
            ram_rdata1 <= mem1[ram_addr1];
        end
    end

    task automatic drive(input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req0 = r; wr = w; size = s; addr = a; wdata = d;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0; wr = 1'b1; size = 2'd2;
        addr = 32'h100; wdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        total++; if (addr_ok0 !== 1'b0) begin bad++; $display("FAIL rst_addr_ok got=%b exp=0", addr_ok0); end
        total++; if (data_ok0 !== 1'b0) begin bad++; $display("FAIL rst_data_ok got=%b exp=0", data_ok0); end
        total++; if (rdata0 !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata0); end
        total++; if (ram_en0 !== 1'b0 || ram_wen0 !== 4'h0) begin bad++; $display("FAIL rst_ram got en=%b wen=%b exp 0", ram_en0, ram_wen0); end
        total++; if (misalign0 !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", misalign0); end
        @(negedge clk); rst = 1'b0; req0 = 1'b0; #1;
        total++; if (addr_ok0 !== 1'b0) begin bad++; $display("FAIL rel_addr_ok_early got=%b exp=0", addr_ok0); end
        @(negedge clk); #1;
        total++; if (addr_ok0 !== 1'b1) begin bad++; $display("FAIL rel_addr_ok got=%b exp=1", addr_ok0); end
    endtask

    task automatic test_word_rw();
        drive(1, 1, 2'd2, 32'h100, 32'hDEAD_BEEF);
        total++; if (addr_ok0 !== 1'b1 || ram_en0 !== 1'b1) begin bad++; $display("FAIL wr_accept got aok=%b en=%b exp 1 1", addr_ok0, ram_en0); end
        total++; if (ram_wen0 !== 4'b1111) begin bad++; $display("FAIL wr_wen got=%b exp=1111", ram_wen0); end
        total++; if (ram_addr0 !== 16'h0040) begin bad++; $display("FAIL wr_ram_addr got=%h exp=0040", ram_addr0); end
        drive(1, 0, 2'd2, 32'h100, 32'h0);
        total++; if (data_ok0 !== 1'b1 || rdata0 !== 32'h0) begin bad++; $display("FAIL wr_resp got dok=%b rdata=%h exp 1 0", data_ok0, rdata0); end
        total++; if (ram_wen0 !== 4'b0000) begin bad++; $display("FAIL rd_wen got=%b exp=0000", ram_wen0); end
        drive(0, 0, 2'd2, 32'h0, 32'h0);
        total++; if (data_ok0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_resp got dok=%b rdata=%h exp 1 deadbeef", data_ok0, rdata0); end
        drive(0, 0, 2'd2, 32'h0, 32'h0);
        total++; if (data_ok0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL idle_hold got dok=%b rdata=%h exp 0 deadbeef", data_ok0, rdata0); end
    endtask

    task automatic test_byte_write();
        drive(1, 1, 2'd2, 32'h100, 32'h1122_3344);
        drive(1, 1, 2'd0, 32'h103, 32'h5A00_0000);
        total++; if (ram_wen0 !== 4'b1000) begin bad++; $display("FAIL byte_wen got=%b exp=1000", ram_wen0); end
        drive(1, 0, 2'd0, 32'h100, 32'h0);
        drive(0, 0, 2'd2, 32'h0, 32'h0);
        total++; if (data_ok0 !== 1'b1 || rdata0 !== 32'h5A22_3344) begin bad++; $display("FAIL byte_read got dok=%b rdata=%h exp 1 5a223344", data_ok0, rdata0); end
    endtask

    task automatic test_misaligned();
        drive(1, 1, 2'd2, 32'h200, 32'hCAFE_F00D);
        drive(1, 1, 2'd1, 32'h201, 32'hFFFF_FFFF);
        total++; if (ram_en0 !== 1'b1 || ram_wen0 !== 4'b0000) begin bad++; $display("FAIL mis_wen got en=%b wen=%b exp 1 0000", ram_en0, ram_wen0); end
        total++; if (data_ok0 !== 1'b1 || misalign0 !== 1'b0) begin bad++; $display("FAIL mis_prev got dok=%b mis=%b exp 1 0", data_ok0, misalign0); end
        drive(1, 0, 2'd2, 32'h202, 32'h0);
        total++; if (data_ok0 !== 1'b1 || misalign0 !== 1'b1 || rdata0 !== 32'h0) begin bad++; $display("FAIL mis_wr_resp got dok=%b mis=%b rdata=%h exp 1 1 0", data_ok0, misalign0, rdata0); end
        drive(1, 0, 2'd2, 32'h200, 32'h0);
        total++; if (data_ok0 !== 1'b1 || misalign0 !== 1'b1 || rdata0 !== 32'hCAFE_F00D) begin bad++; $display("FAIL mis_rd_resp got dok=%b mis=%b rdata=%h exp 1 1 cafef00d", data_ok0, misalign0, rdata0); end
        drive(0, 0, 2'd2, 32'h0, 32'h0);
        total++; if (data_ok0 !== 1'b1 || misalign0 !== 1'b0 || rdata0 !== 32'hCAFE_F00D) begin bad++; $display("FAIL mis_unchanged got dok=%b mis=%b rdata=%h exp 1 0 cafef00d", data_ok0, misalign0, rdata0); end
        drive(0, 0, 2'd2, 32'h0, 32'h0);
        total++; if (data_ok0 !== 1'b0 || misalign0 !== 1'b0) begin bad++; $display("FAIL mis_idle got dok=%b mis=%b exp 0 0", data_ok0, misalign0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic [31:0] exp_rd;
        vals[0] = 32'h0101_A0A0; vals[1] = 32'h0202_B0B0;
        vals[2] = 32'h0303_C0C0; vals[3] = 32'h0404_D0D0;
        for (int t = 0; t < 10; t++) begin
            drive(t < 8, t < 4, 2'd2, 32'h300 + 32'(4 * (t % 4)), vals[t % 4]);
            total++; if (addr_ok0 !== 1'b1) begin bad++; $display("FAIL b2b_addr_ok t=%0d got=%b exp=1", t, addr_ok0); end
            total++; if (data_ok0 !== (t >= 1 && t <= 8)) begin bad++; $display("FAIL b2b_data_ok t=%0d got=%b exp=%b", t, data_ok0, (t >= 1 && t <= 8)); end
            if (t >= 1 && t <= 8) begin
                exp_rd = (t <= 4) ? 32'h0 : vals[t - 5];
                total++; if (rdata0 !== exp_rd) begin bad++; $display("FAIL b2b_rdata t=%0d got=%h exp=%h", t, rdata0, exp_rd); end
            end
        end
    endtask

    task automatic test_full_stall();
        int   due_q[$];
        int   outst;
        logic exp_aok, exp_dok;
        outst = 0;
        req0 = 1'b0; wr = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'h0BAD_F00D;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            req1 = (t < 6);
            #1;
            exp_aok = (outst < 2);
            exp_dok = (due_q.size() > 0) && (due_q[0] == t);
            total++; if (addr_ok1 !== exp_aok) begin bad++; $display("FAIL stall_addr_ok t=%0d got=%b exp=%b", t, addr_ok1, exp_aok); end
            total++; if (data_ok1 !== exp_dok) begin bad++; $display("FAIL stall_data_ok t=%0d got=%b exp=%b", t, data_ok1, exp_dok); end
            if (exp_dok) begin
                void'(due_q.pop_front());
                outst--;
            end
            if (req1 && exp_aok) begin
                due_q.push_back(t + 4);
                outst++;
            end
        end
        req1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        req0 = 1'b0; wr = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h1234_5678;
        @(negedge clk); req1 = 1'b1; #1;
        total++; if (addr_ok1 !== 1'b1) begin bad++; $display("FAIL mid_acc1 got=%b exp=1", addr_ok1); end
        @(negedge clk); #1;
        total++; if (addr_ok1 !== 1'b1) begin bad++; $display("FAIL mid_acc2 got=%b exp=1", addr_ok1); end
        @(negedge clk); req1 = 1'b0; rst = 1'b1; #1;
        total++; if (addr_ok1 !== 1'b0 || addr_ok0 !== 1'b0 || data_ok1 !== 1'b0) begin bad++; $display("FAIL mid_in_rst got aok1=%b aok0=%b dok1=%b exp 0 0 0", addr_ok1, addr_ok0, data_ok1); end
        @(negedge clk); #1;
        total++; if (addr_ok1 !== 1'b0 || data_ok1 !== 1'b0) begin bad++; $display("FAIL mid_in_rst2 got aok=%b dok=%b exp 0 0", addr_ok1, data_ok1); end
        @(negedge clk); rst = 1'b0; #1;
        total++; if (addr_ok1 !== 1'b0) begin bad++; $display("FAIL mid_rel got=%b exp=0", addr_ok1); end
        for (int t = 0; t < 8; t++) begin
            @(negedge clk); #1;
            total++; if (data_ok1 !== 1'b0 || addr_ok1 !== 1'b1) begin bad++; $display("FAIL mid_after t=%0d got dok=%b aok=%b exp 0 1", t, data_ok1, addr_ok1); end
        end
        drive(1, 0, 2'd2, 32'h100, 32'h0);
        drive(0, 0, 2'd2, 32'h0, 32'h0);
        total++; if (data_ok0 !== 1'b1 || rdata0 !== 32'h5A22_3344) begin bad++; $display("FAIL mid_mem_kept got dok=%b rdata=%h exp 1 5a223344", data_ok0, rdata0); end
    endtask

    // Random traffic on the zero-latency instance against a byte-level model.
    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [31:0] ref_mem [16];
        logic [31:0] word;
        int          outst, nb, lo, idx;
        logic        exp_aok, exp_dok, al;
        logic [3:0]  exp_wen;
        outst = 0;
        req1 = 1'b0;
        for (int t = 0; t < 240; t++) begin
            @(negedge clk);
            if (t < 16) begin
                req0 = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h400 + 32'(4 * t); wdata = $urandom;
            end else if (t < 220) begin
                req0 = ($urandom_range(0, 3) != 0); wr = 1'($urandom_range(0, 1));
                size = 2'($urandom_range(0, 3)); addr = 32'h400 + 32'($urandom_range(0, 63));
                wdata = $urandom;
            end else begin
                req0 = 1'b0;
            end
            #1;
            exp_aok = (outst < 2);
            exp_dok = (q.size() > 0) && (q[0].due == t);
            total++; if (addr_ok0 !== exp_aok) begin bad++; $display("FAIL rnd_addr_ok t=%0d got=%b exp=%b", t, addr_ok0, exp_aok); end
            total++; if (data_ok0 !== exp_dok) begin bad++; $display("FAIL rnd_data_ok t=%0d got=%b exp=%b", t, data_ok0, exp_dok); end
            if (exp_dok) begin
                e = q.pop_front();
                outst--;
                total++; if (rdata0 !== e.data || misalign0 !== e.mis) begin bad++; $display("FAIL rnd_resp t=%0d got rdata=%h mis=%b exp %h %b", t, rdata0, misalign0, e.data, e.mis); end
            end
            if (req0 && exp_aok) begin
                nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
                lo  = int'(addr % 4);
                al  = (lo % nb) == 0;
                idx = int'((addr - 32'h400) / 4);
                exp_wen = (wr && al) ? 4'(((1 << nb) - 1) << lo) : 4'b0000;
                total++; if (ram_wen0 !== exp_wen || ram_addr0 !== 16'(addr >> 2)) begin bad++; $display("FAIL rnd_ram t=%0d got wen=%b addr=%h exp %b %h", t, ram_wen0, ram_addr0, exp_wen, 16'(addr >> 2)); end
                e.due = t + 1;
                e.mis = !al;
                if (wr) begin
                    e.data = 32'h0;
                    if (al) begin
                        word = ref_mem[idx];
                        for (int k = 0; k < nb; k++) word[8*(lo + k) +: 8] = wdata[8*(lo + k) +: 8];
                        ref_mem[idx] = word;
                    end
                end else begin
                    e.data = ref_mem[idx];
                end
                q.push_back(e);
                outst++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_write();
        test_misaligned();
        test_back_to_back();
        test_full_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
